delayed_gate_bank: RTL and testbench
====================================

DELAYED_GATE_BANK -- requirements
Module: delayed_gate_bank

Interface
REQ-001 Parameter NCH, default 8: number of independent gate channels (1..32).
REQ-002 Parameter DW, default 32: width of each channel's delay value, in clock cycles.
REQ-003 Port clk, input, 1: single system clock; all logic rising-edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port enable, input, 1: global run; 0 forces all channels idle.
REQ-006 Port gate, input, NCH: per-channel raw gate request, synchronous to clk.
REQ-007 Port on_delay, input, NCH*DW: per-channel turn-on delay; channel i occupies bits [i*DW +: DW].
REQ-008 Port off_delay, input, NCH*DW: per-channel turn-off delay; same packing as on_delay.
REQ-009 Port mode, input, NCH: per-channel mode; 0 = delayed-on/immediate-off, 1 = delayed-on/delayed-off.
REQ-010 Port q, output, NCH: registered gated output per channel.
REQ-011 Port busy, output, NCH: per-channel flag, 1 while a delay count is in progress.

Function
REQ-012 Each channel SHALL implement an independent FSM with states OFF, ARM_ON, ON, ARM_OFF.
REQ-013 q SHALL be 1 in states ON and ARM_OFF only; busy SHALL be 1 in ARM_ON and ARM_OFF only.
REQ-014 OFF, gate sampled 1: go to ARM_ON, latch on_delay into the channel counter; if on_delay = 0, go directly to ON (q high after that same edge).
REQ-015 ARM_ON: q SHALL go high after edge k+D when gate is sampled 1 at every edge k..k+D, where D = latched on_delay.
REQ-016 ARM_ON, gate sampled 0: return to OFF; q stays 0 (pulses of D cycles or fewer are suppressed).
REQ-017 ON, gate sampled 0, mode = 0: go to OFF; q low after that same edge.
REQ-018 ON, gate sampled 0, mode = 1: go to ARM_OFF, latch off_delay; if off_delay = 0, go directly to OFF.
REQ-019 ARM_OFF: q SHALL go low after edge j+E when gate is sampled 0 at every edge j..j+E, where E = latched off_delay.
REQ-020 ARM_OFF, gate sampled 1: return to ON; q stays 1 without a glitch.
REQ-021 Delay and mode inputs SHALL be sampled only at ARM entry; changes mid-count SHALL not affect the running count.
REQ-022 The counter SHALL be DW bits wide, load the delay value and count down to 0; no wrap-around; maximum delay is 2^DW-1.
REQ-023 enable = 0 SHALL force every channel to OFF synchronously; q = 0 and busy = 0 after that edge.
REQ-024 Channels SHALL not interact; simultaneous transitions on all channels SHALL be supported in the same cycle.

Reset
REQ-025 reset_n = 0 SHALL asynchronously force all channels to OFF, all counters to 0, q = 0 and busy = 0.
REQ-026 Reset asserted mid-count SHALL abort the count; after release, a channel SHALL re-arm only on a fresh gate sample.

Structure
REQ-027 FSM state encoding and the mode encoding constants SHALL reside in the shared timing package.
REQ-028 One sub-module, delayed_gate_channel (one FSM plus counter), SHALL be instantiated NCH times from a generate loop.

Verification
REQ-029 20 ns clock, ch0 on_delay = 10, mode = 0, gate high 400 ns -> q high exactly 10 cycles after the first high sample; q low on the edge after gate falls.
REQ-030 ch0 on_delay = 10, gate high 60 ns (3 cycles) -> q remains 0; busy high for 3 cycles.
REQ-031 ch1 mode = 1, on_delay = 0, off_delay = 5, gate high 10 cycles then low -> q high after the first edge, and low 5 cycles after the first low sample.
REQ-032 ch1 mode = 1, off_delay = 5, gate low 2 cycles then high again -> q stays high continuously.
REQ-033 All NCH channels armed with on_delay = 100; reset_n pulsed low at count 50 -> q = 0 immediately; no assertion occurs until gate is re-sampled high.
REQ-034 enable dropped while ch2 is in ARM_OFF with q high -> q low after the next edge; on_delay changed to 3 mid-count on ch3 (originally 20) -> q rises after the original 20 cycles.

Source files
------------

// File: rtl/delayed_gate_bank_pkg.sv
// Shared timing package for the delayed gate bank: channel FSM state
// encoding, mode encoding and output decode helpers.
package delayed_gate_bank_pkg;

    // Encoding chosen so q = state[1] and busy = state[0].
    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_ARM_ON  = 2'b01,
        ST_ON      = 2'b10,
        ST_ARM_OFF = 2'b11
    } gate_state_e;

    localparam logic MODE_IMM_OFF = 1'b0;  // delayed-on / immediate-off
    localparam logic MODE_DLY_OFF = 1'b1;  // delayed-on / delayed-off

    function automatic logic state_drives_q(input gate_state_e s);
        return (s == ST_ON) || (s == ST_ARM_OFF);
    endfunction

    function automatic logic state_is_busy(input gate_state_e s);
        return (s == ST_ARM_ON) || (s == ST_ARM_OFF);
    endfunction

endpackage

// File: rtl/delayed_gate_channel.sv
// One gate channel: four-state FSM plus a down-counting delay timer.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   ST_OFF     | output low, waiting for a gate request
//   ST_ARM_ON  | gate held high, counting down the latched on-delay
//   ST_ON      | output high, gate still requested
//   ST_ARM_OFF | gate dropped (mode 1), counting down the off-delay
//
// The counter is loaded when an ARM state is entered and the FSM moves on
// when the count would reach zero, so a delay of D takes D further samples
// after the arming sample.
module delayed_gate_channel
    import delayed_gate_bank_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    input  logic          gate_i,
    input  logic          mode_i,
    input  logic [DW-1:0] on_delay_i,
    input  logic [DW-1:0] off_delay_i,
    output logic          q_o,
    output logic          busy_o
);

    localparam logic [DW-1:0] CNT_ONE = DW'(1);

    gate_state_e   state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          q_q, busy_q;

    // Next-state and counter logic; enable low overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (gate_i) begin
                        if (on_delay_i == '0) begin
                            state_d = ST_ON;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_ARM_ON;
                            cnt_d   = on_delay_i;
                        end
                    end
                end
                ST_ARM_ON: begin
                    if (!gate_i) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (!gate_i) begin
                        if (mode_i == MODE_IMM_OFF || off_delay_i == '0) begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_ARM_OFF;
                            cnt_d   = off_delay_i;
                        end
                    end
                end
                ST_ARM_OFF: begin
                    if (gate_i) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; reset aborts any count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= state_drives_q(state_d);
            busy_q  <= state_is_busy(state_d);
        end
    end

    assign q_o    = q_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/delayed_gate_bank.sv
// Bank of NCH independent delayed gate channels sharing clock, reset and
// the global enable. Delay buses are packed with channel i at [i*DW +: DW].
module delayed_gate_bank #(
    parameter int NCH = 8,
    parameter int DW  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [NCH-1:0]   gate,
    input  logic [NCH*DW-1:0] on_delay,
    input  logic [NCH*DW-1:0] off_delay,
    input  logic [NCH-1:0]   mode,
    output logic [NCH-1:0]   q,
    output logic [NCH-1:0]   busy
);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        delayed_gate_channel #(
            .DW(DW)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (reset_n),
            .enable_i    (enable),
            .gate_i      (gate[gi]),
            .mode_i      (mode[gi]),
            .on_delay_i  (on_delay[gi*DW +: DW]),
            .off_delay_i (off_delay[gi*DW +: DW]),
            .q_o         (q[gi]),
            .busy_o      (busy[gi])
        );
    end

endmodule

// File: tb/tb_delayed_gate_bank.sv
// Self-checking bench for delayed_gate_bank: a hand-derived vector table on
// channel 0, directed multi-cycle sequences, and a randomized run, all also
// checked every cycle against a run-length reference model.
module tb_delayed_gate_bank;

    localparam int NCH = 8;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [NCH-1:0]    gate;
    logic [NCH*DW-1:0] on_delay;
    logic [NCH*DW-1:0] off_delay;
    logic [NCH-1:0]    mode;
    logic [NCH-1:0]    q;
    logic [NCH-1:0]    busy;

    int n_vec = 0;
    int n_err = 0;

    delayed_gate_bank #(.NCH(NCH), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .gate      (gate),
        .on_delay  (on_delay),
        .off_delay (off_delay),
        .mode      (mode),
        .q         (q),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a channel's output flips once the gate has been seen
    // opposite to the output for (latched delay + 1) consecutive samples.
    int     m_run [NCH];
    longint m_lim [NCH];
    bit     m_q   [NCH];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0;
            m_lim[i] = 0;
            m_q[i]   = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < NCH; i++) begin
            if (!enable) begin
                m_q[i]   = 1'b0;
                m_run[i] = 0;
            end else if (!m_q[i]) begin
                if (gate[i]) begin
                    if (m_run[i] == 0) m_lim[i] = longint'(on_delay[i*DW +: DW]);
                    m_run[i]++;
                    if (m_run[i] > m_lim[i]) begin
                        m_q[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else begin
                if (gate[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] == 0 && !mode[i]) begin
                    m_q[i] = 1'b0;
                end else begin
                    if (m_run[i] == 0) m_lim[i] = longint'(off_delay[i*DW +: DW]);
                    m_run[i]++;
                    if (m_run[i] > m_lim[i]) begin
                        m_q[i]   = 1'b0;
                        m_run[i] = 0;
                    end
                end
            end
        end
    endfunction

    function automatic logic [NCH-1:0] model_qv();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_q[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] model_busyv();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_run[i] > 0);
        return v;
    endfunction

    task automatic chk_vec(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock: model steps on the rising edge, outputs compared at the falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge();
        @(negedge clk);
        chk_vec({tag, " model q"},    q,    model_qv());
        chk_vec({tag, " model busy"}, busy, model_busyv());
    endtask

    task automatic set_on(input int ch, input int v);
        on_delay[ch*DW +: DW] = DW'(v);
    endtask

    task automatic set_off(input int ch, input int v);
        off_delay[ch*DW +: DW] = DW'(v);
    endtask

    task automatic flush();
        gate   = '0;
        enable = 1'b0;
        cycle("flush");
        enable = 1'b1;
    endtask

    typedef struct {
        bit g;
        int on_d;
        int off_d;
        bit md;
        bit eq;
        bit eb;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // g, on_delay, off_delay, mode, expected q, expected busy (channel 0)
        tbl.push_back('{1'b1, 2, 0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 2, 0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 2, 0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 2, 0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 2, 0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 2, 0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 0, 1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 0, 1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 0, 2, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 2, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 0, 2, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 0, 0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1, 3, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1, 3, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1, 3, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 9, 9, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 9, 9, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 9, 9, 1'b0, 1'b0, 1'b0});

        reset_n   = 1'b0;
        enable    = 1'b0;
        gate      = '0;
        mode      = '0;
        on_delay  = '0;
        off_delay = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        chk_vec("reset q", q, '0);
        chk_vec("reset busy", busy, '0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        cycle("idle");

        // Vector table on channel 0
        foreach (tbl[t]) begin
            gate[0] = tbl[t].g;
            set_on(0, tbl[t].on_d);
            set_off(0, tbl[t].off_d);
            mode[0] = tbl[t].md;
            cycle("table");
            chk_bit($sformatf("table[%0d] q0", t), q[0], tbl[t].eq);
            chk_bit($sformatf("table[%0d] busy0", t), busy[0], tbl[t].eb);
        end

        // ch0 on_delay 10, gate high 20 cycles: q rises exactly at the 10th edge after first sample
        flush();
        set_on(0, 10);
        mode[0] = 1'b0;
        gate[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle("on10");
            chk_bit($sformatf("on10 q0 k=%0d", k), q[0], (k >= 10));
        end
        gate[0] = 1'b0;
        cycle("on10 fall");
        chk_bit("on10 fall q0", q[0], 1'b0);

        // ch0 short pulse of 3 cycles: suppressed, busy for 3 cycles
        flush();
        set_on(0, 10);
        gate[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle("pulse3");
            chk_bit($sformatf("pulse3 busy0 k=%0d", k), busy[0], 1'b1);
            chk_bit($sformatf("pulse3 q0 k=%0d", k), q[0], 1'b0);
        end
        gate[0] = 1'b0;
        cycle("pulse3 end");
        chk_bit("pulse3 end busy0", busy[0], 1'b0);
        chk_bit("pulse3 end q0", q[0], 1'b0);

        // ch1 mode 1, on 0, off 5
        flush();
        mode[1] = 1'b1;
        set_on(1, 0);
        set_off(1, 5);
        gate[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle("ch1 on");
            chk_bit($sformatf("ch1 on q1 k=%0d", k), q[1], 1'b1);
        end
        gate[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle("ch1 off");
            chk_bit($sformatf("ch1 off q1 k=%0d", k), q[1], (k < 5));
        end

        // ch1 gate low 2 cycles then high again: q stays high
        gate[1] = 1'b1;
        cycle("ch1 rearm");
        chk_bit("ch1 rearm q1", q[1], 1'b1);
        gate[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle("ch1 dip");
            chk_bit($sformatf("ch1 dip q1 k=%0d", k), q[1], 1'b1);
        end
        gate[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle("ch1 back");
            chk_bit($sformatf("ch1 back q1 k=%0d", k), q[1], 1'b1);
        end
        chk_bit("ch1 back busy1", busy[1], 1'b0);

        // All channels armed with on_delay 100, reset mid-count
        flush();
        for (int i = 0; i < NCH; i++) set_on(i, 100);
        mode = '0;
        gate = '1;
        for (int k = 0; k < 50; k++) cycle("all arm");
        chk_vec("all arm busy", busy, '1);
        chk_vec("all arm q", q, '0);
        reset_n = 1'b0;
        #1;
        chk_vec("async reset q", q, '0);
        chk_vec("async reset busy", busy, '0);
        gate = '0;
        cycle("in reset");
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) cycle("post reset idle");
        chk_vec("post reset q", q, '0);
        chk_vec("post reset busy", busy, '0);
        gate = '1;
        for (int k = 0; k < 101; k++) begin
            cycle("rearm");
            if (k == 99)  chk_vec("rearm q before", q, '0);
            if (k == 100) chk_vec("rearm q after", q, '1);
        end

        // enable dropped while ch2 in ARM_OFF with q high
        flush();
        mode[2] = 1'b1;
        set_on(2, 0);
        set_off(2, 50);
        gate[2] = 1'b1;
        cycle("ch2 on");
        gate[2] = 1'b0;
        for (int k = 0; k < 3; k++) cycle("ch2 arm_off");
        chk_bit("ch2 arm_off q2", q[2], 1'b1);
        chk_bit("ch2 arm_off busy2", busy[2], 1'b1);
        enable = 1'b0;
        cycle("ch2 disable");
        chk_bit("ch2 disable q2", q[2], 1'b0);
        chk_bit("ch2 disable busy2", busy[2], 1'b0);
        enable = 1'b1;

        // ch3 on_delay changed mid-count: original 20 still applies
        mode[3] = 1'b0;
        set_on(3, 20);
        gate[3] = 1'b1;
        cycle("ch3 arm");
        set_on(3, 3);
        for (int k = 1; k <= 20; k++) begin
            cycle("ch3 count");
            chk_bit($sformatf("ch3 q3 k=%0d", k), q[3], (k >= 20));
        end

        // Randomized run against the model
        flush();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(3) == 0) gate[i] = ~gate[i];
                set_on(i, int'($urandom_range(6)));
                set_off(i, int'($urandom_range(6)));
                mode[i] = 1'($urandom_range(1));
            end
            enable = ($urandom_range(31) != 0);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
